// File: rtl/load_use_hazard_ctrl.sv
// Load-use interlock detection for the 5-stage MIPS pipeline.
// A load in EX whose destination is read by the ID instruction freezes PC
// and IF/ID and bubbles ID/EX for STALL_CYCLES cycles. The cycle after the
// stall tells the EX forwarding mux which operands take the delayed load data.
module load_use_hazard_ctrl #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             pipe_freeze,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_flush,
  output logic             ld_fwd_rs,
  output logic             ld_fwd_rt,
  output logic [CNT_W-1:0] hazard_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(STALL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       match_q, match_d;   // {rs, rt}
  logic [CNT_W-1:0] hcnt_q, hcnt_d;

  logic m_rs, m_rt, haz, stall;

  // Operand match against the load in EX; $0 is never a real destination
  always_comb begin
    m_rs = id_use_rs & (id_rs == ex_rd);
    m_rt = id_use_rt & (id_rt == ex_rd);
    haz  = ex_mem_read & ex_reg_write & (ex_rd != 5'd0) & (m_rs | m_rt);
  end

  // Next-state logic; a freeze leaves every register at its current value
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    hcnt_d  = hcnt_q;
    if (!pipe_freeze) begin
      unique case (state_q)
        IDLE, RELEASE: begin
          if (haz) begin
            match_d = {m_rs, m_rt};
            if (hcnt_q != '1) hcnt_d = hcnt_q + CNT_W'(1);
            if (STALL_CYCLES == 1) begin
              state_d = RELEASE;
            end else begin
              state_d = STALL;
              cnt_d   = CNT_INIT;
            end
          end else begin
            state_d = IDLE;
          end
        end
        STALL: begin
          if (cnt_q == 4'd1) state_d = RELEASE;
          else               cnt_d   = cnt_q - 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode: detection stalls combinationally, STALL holds regardless of haz
  always_comb begin
    stall     = (state_q == STALL) | haz;
    ld_fwd_rs = (state_q == RELEASE) & match_q[1];
    ld_fwd_rt = (state_q == RELEASE) & match_q[0];
  end

  assign pc_stall   = stall;
  assign ifid_stall = stall;
  assign idex_flush = stall;
  assign hazard_cnt = hcnt_q;

  // State registers with synchronous reset taking priority over freeze
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      match_q <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      hcnt_q  <= hcnt_d;
    end
  end

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Bench for load_use_hazard_ctrl: three instances with different stall
// lengths / counter widths share one stimulus stream; each has its own
// behavioural model checked every cycle, plus hand-computed literal checks.
module tb_load_use_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_mem_read, ex_reg_write, pipe_freeze;

  logic [2:0]  pc_s, ifid_s, idex_f, fwd_rs, fwd_rt;
  logic [15:0] hc_a, hc_b;
  logic [1:0]  hc_c;
  int          hc [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_use_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .pipe_freeze(pipe_freeze),
    .pc_stall(pc_s[0]), .ifid_stall(ifid_s[0]), .idex_flush(idex_f[0]),
    .ld_fwd_rs(fwd_rs[0]), .ld_fwd_rt(fwd_rt[0]), .hazard_cnt(hc_a));

  load_use_hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .pipe_freeze(pipe_freeze),
    .pc_stall(pc_s[1]), .ifid_stall(ifid_s[1]), .idex_flush(idex_f[1]),
    .ld_fwd_rs(fwd_rs[1]), .ld_fwd_rt(fwd_rt[1]), .hazard_cnt(hc_b));

  load_use_hazard_ctrl #(.STALL_CYCLES(2), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .pipe_freeze(pipe_freeze),
    .pc_stall(pc_s[2]), .ifid_stall(ifid_s[2]), .idex_flush(idex_f[2]),
    .ld_fwd_rs(fwd_rs[2]), .ld_fwd_rt(fwd_rt[2]), .hazard_cnt(hc_c));

  always_comb begin
    hc[0] = int'(hc_a);
    hc[1] = int'(hc_b);
    hc[2] = int'(hc_c);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // rem: stall cycles still owed after this one; rel: next non-stall cycle
  // presents the forwarding flags; mrs/mrt: operands matched at detection.
  int NSTALL [3] = '{1, 3, 2};
  int CMAX   [3] = '{65535, 65535, 3};
  int rem [3], hcm [3];
  bit rel [3], mrs [3], mrt [3];
  bit mvalid = 1'b0;

  function automatic bit m_rs_f();
    return id_use_rs && (id_rs == ex_rd);
  endfunction
  function automatic bit m_rt_f();
    return id_use_rt && (id_rt == ex_rd);
  endfunction
  function automatic bit haz_f();
    return ex_mem_read && ex_reg_write && (ex_rd != 0) && (m_rs_f() || m_rt_f());
  endfunction

  // model update on the active edge
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        rem[k] = 0; rel[k] = 0; mrs[k] = 0; mrt[k] = 0; hcm[k] = 0;
      end else if (!mvalid || pipe_freeze) begin
        // hold
      end else if (rem[k] > 0) begin
        rem[k] = rem[k] - 1;
        if (rem[k] == 0) rel[k] = 1;
      end else if (haz_f()) begin
        mrs[k] = m_rs_f();
        mrt[k] = m_rt_f();
        if (hcm[k] < CMAX[k]) hcm[k] = hcm[k] + 1;
        rem[k] = NSTALL[k] - 1;
        rel[k] = (NSTALL[k] == 1);
      end else begin
        rel[k] = 0;
      end
    end
    if (rst) mvalid = 1'b1;
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < 3; k++) begin
        bit es, efr, eft;
        es  = (rem[k] > 0) ? 1'b1 : haz_f();
        efr = (rem[k] == 0) && rel[k] && mrs[k];
        eft = (rem[k] == 0) && rel[k] && mrt[k];
        chk($sformatf("m%0d.pc_stall", k),   int'(pc_s[k]),   int'(es));
        chk($sformatf("m%0d.ifid_stall", k), int'(ifid_s[k]), int'(es));
        chk($sformatf("m%0d.idex_flush", k), int'(idex_f[k]), int'(es));
        chk($sformatf("m%0d.ld_fwd_rs", k),  int'(fwd_rs[k]), int'(efr));
        chk($sformatf("m%0d.ld_fwd_rt", k),  int'(fwd_rt[k]), int'(eft));
        chk($sformatf("m%0d.hazard_cnt", k), hc[k],           hcm[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0; ex_reg_write = 0;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                    input logic urs, input logic urt);
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = rd;
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) tick();
  endtask

  initial begin
    clr();
    rst = 1; pipe_freeze = 0;
    tick(); tick(); #2;
    chk("rst.pc_stall", int'(pc_s[0]), 0);
    chk("rst.fwd_rs",   int'(fwd_rs[1]), 0);
    chk("rst.cnt_a",    hc[0], 0);
    chk("rst.cnt_b",    hc[1], 0);
    tick(); rst = 0;
    idle(2);

    // 1: single-cycle stall, then rs flag
    ld(8, 8, 0, 1, 0); #2;
    chk("t1.det_pc",  int'(pc_s[0]), 1);
    chk("t1.det_fwd", int'(fwd_rs[0]), 0);
    tick(); clr(); #2;
    chk("t1.rel_fwd_rs", int'(fwd_rs[0]), 1);
    chk("t1.rel_fwd_rt", int'(fwd_rt[0]), 0);
    chk("t1.rel_pc",     int'(pc_s[0]), 0);
    chk("t1.cnt",        hc[0], 1);
    idle(5);

    // 2: $0 destination and non-load writer never stall
    ld(0, 0, 0, 1, 0); #2;
    chk("t2.r0_pc", int'(pc_s[0]), 0);
    tick();
    ex_mem_read = 0; ex_reg_write = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1; #2;
    chk("t2.alu_pc", int'(pc_s[1]), 0);
    tick(); clr(); #2;
    chk("t2.fwd", int'(fwd_rs[0]), 0);
    chk("t2.cnt", hc[0], 1);
    idle(5);

    // 3: three-cycle stall, both operands
    ld(5, 5, 5, 1, 1); #2;
    chk("t3.c0_pc", int'(pc_s[1]), 1);
    tick(); clr(); #2;
    chk("t3.c1_pc", int'(pc_s[1]), 1);
    chk("t3.c1_fwd", int'(fwd_rs[1]), 0);
    tick(); #2;
    chk("t3.c2_pc", int'(pc_s[1]), 1);
    tick(); #2;
    chk("t3.c3_pc", int'(pc_s[1]), 0);
    chk("t3.c3_fwd_rs", int'(fwd_rs[1]), 1);
    chk("t3.c3_fwd_rt", int'(fwd_rt[1]), 1);
    tick(); #2;
    chk("t3.c4_fwd_rs", int'(fwd_rs[1]), 0);
    chk("t3.cnt", hc[1], 2);
    idle(5);

    // 4: freeze stretches the stall, then holds the release flags
    ld(5, 5, 0, 1, 0); #2;
    tick(); clr(); pipe_freeze = 1; #2;
    chk("t4.c1_pc", int'(pc_s[1]), 1);
    tick(); #2;
    chk("t4.c2_pc", int'(pc_s[1]), 1);
    tick(); pipe_freeze = 0; #2;
    chk("t4.c3_pc", int'(pc_s[1]), 1);
    tick(); #2;
    chk("t4.c4_pc", int'(pc_s[1]), 1);
    tick(); pipe_freeze = 1; #2;
    chk("t4.c5_pc", int'(pc_s[1]), 0);
    chk("t4.c5_fwd_rs", int'(fwd_rs[1]), 1);
    chk("t4.c5_fwd_rt", int'(fwd_rt[1]), 0);
    tick(); #2;
    chk("t4.c6_fwd_rs", int'(fwd_rs[1]), 1);
    tick(); #2;
    chk("t4.c7_fwd_rs", int'(fwd_rs[1]), 1);
    tick(); pipe_freeze = 0; #2;
    chk("t4.c8_fwd_rs", int'(fwd_rs[1]), 1);
    tick(); #2;
    chk("t4.c9_fwd_rs", int'(fwd_rs[1]), 0);
    chk("t4.cnt", hc[1], 3);
    idle(5);

    // 5: back-to-back hazard detected in the release cycle
    ld(8, 8, 0, 1, 0);
    tick(); ld(7, 0, 7, 0, 1); #2;
    chk("t5.c1_pc",     int'(pc_s[0]), 1);
    chk("t5.c1_fwd_rs", int'(fwd_rs[0]), 1);
    chk("t5.c1_fwd_rt", int'(fwd_rt[0]), 0);
    tick(); clr(); #2;
    chk("t5.c2_fwd_rs", int'(fwd_rs[0]), 0);
    chk("t5.c2_fwd_rt", int'(fwd_rt[0]), 1);
    chk("t5.c2_pc",     int'(pc_s[0]), 0);
    chk("t5.cnt",       hc[0], 5);
    idle(5);

    // 6: saturation on the narrow counter, reset mid-stall beats freeze
    chk("t6.sat", hc[2], 3);
    ld(9, 9, 0, 1, 0);
    tick(); clr(); rst = 1; pipe_freeze = 1; #2;
    chk("t6.mid_stall", int'(pc_s[1]), 1);
    tick(); rst = 0; pipe_freeze = 0; #2;
    chk("t6.rst_pc",  int'(pc_s[1]), 0);
    chk("t6.rst_fwd", int'(fwd_rs[0]), 0);
    chk("t6.rst_cb",  hc[1], 0);
    chk("t6.rst_cc",  hc[2], 0);
    idle(2);

    // short random soak on a small register space, model-checked
    for (int i = 0; i < 400; i++) begin
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_use_rs    = 1'($urandom_range(0, 1));
      id_use_rt    = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_reg_write = ($urandom_range(0, 3) != 0);
      pipe_freeze  = ($urandom_range(0, 4) == 0);
      rst          = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 0; pipe_freeze = 0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
